// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter sharing one 16x8 single-port synchronous RAM between two requesters.
// Latency: handshake at edge T, RAM op at edge T+1, rsp pulse visible after edge T+2 (3 cycles/transaction).
// Backpressure: reqN_ready only in IDLE and only for the granted requester; requesters hold commands until ready.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   reqN_valid/ready         command handshake per requester (N = 0, 1)
//   reqN_we/addr/wdata       command: write enable, address, write data
//   rspN_valid/rdata         one-cycle completion pulse and registered read data
//   ram_we/addr/din/dout     RAM interface (dout registered, valid the cycle after addr is sampled)
//   busy                     high whenever a transaction is in flight
module ram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic              last_gnt;   // id of the most recent grant; reset to 1 so requester 0 wins first
  logic              gnt_id;     // requester owning the in-flight transaction
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              take;

  // Next state and grant. On contention requester 0 wins only when
  // requester 1 was granted last.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_gnt)) begin
          req0_ready = 1'b1;
        end else if (req1_valid) begin
          req1_ready = 1'b1;
        end
        if (req0_ready || req1_ready) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign take = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt   <= 1'b1;
      gnt_id     <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (take) begin
        gnt_id    <= req1_ready;
        last_gnt  <= req1_ready;
        cmd_we    <= req1_ready ? req1_we    : req0_we;
        cmd_addr  <= req1_ready ? req1_addr  : req0_addr;
        cmd_wdata <= req1_ready ? req1_wdata : req0_wdata;
      end
      // ram_dout holds the word addressed during ACCESS; capture it while
      // leaving RESP so rdata and the pulse appear together.
      if (state == RESP) begin
        if (!gnt_id) begin
          rsp0_valid <= 1'b1;
          if (!cmd_we) rsp0_rdata <= ram_dout;
        end else begin
          rsp1_valid <= 1'b1;
          if (!cmd_we) rsp1_rdata <= ram_dout;
        end
      end
    end
  end

  // The latched command is presented continuously; only ACCESS may write.
  assign ram_we   = (state == ACCESS) && cmd_we;
  assign ram_addr = cmd_addr;
  assign ram_din  = cmd_wdata;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req0_we;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       rsp0_valid;
  logic [7:0] rsp0_rdata;
  logic       req1_valid, req1_ready, req1_we;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       rsp1_valid;
  logic [7:0] rsp1_rdata;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int we_cnt = 0;
  int cyc = 0;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with registered output.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge clk) if (ram_we) we_cnt++;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [3:0] a, input logic [7:0] d);
    if (p == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // One transaction from an idle arbiter; checks every cycle of the 3-cycle turnaround.
  task automatic txn(input int p, input logic we, input logic [3:0] a,
                     input logic [7:0] d, input logic [7:0] exp_rd);
    int n;
    int we0;
    logic [7:0] rd_before;
    rd_before = (p == 1) ? rsp1_rdata : rsp0_rdata;
    set_req(p, 1, we, a, d);
    #1;
    n = 0;
    while (!((p == 1) ? req1_ready : req0_ready) && n < 20) begin
      tick();
      n++;
    end
    chk("rdy_wait", n, 0);
    chk("rdy_other", (p == 1) ? req0_ready : req1_ready, 0);
    we0 = we_cnt;
    tick();                       // handshake edge
    set_req(p, 0, 0, 0, 0);
    #1;
    chk("acc_busy", busy, 1);
    chk("acc_we", ram_we, we);
    chk("acc_addr", ram_addr, a);
    if (we) chk("acc_din", ram_din, d);
    chk("acc_rdy", {req0_ready, req1_ready}, 0);
    tick();                       // RAM op edge
    chk("resp_we", ram_we, 0);
    chk("resp_busy", busy, 1);
    chk("resp_nopulse", {rsp0_valid, rsp1_valid}, 0);
    tick();
    chk("rsp_mine", (p == 1) ? rsp1_valid : rsp0_valid, 1);
    chk("rsp_other", (p == 1) ? rsp0_valid : rsp1_valid, 0);
    chk("rdata", (p == 1) ? rsp1_rdata : rsp0_rdata, we ? rd_before : exp_rd);
    chk("we_pulses", we_cnt - we0, we ? 1 : 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("rsp_single", {rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    int n;
    int g;
    int t0;

    // T1: reset state
    do_reset();
    chk("t1_busy", busy, 0);
    chk("t1_ram_we", ram_we, 0);
    chk("t1_ram_addr", ram_addr, 0);
    chk("t1_ram_din", ram_din, 0);
    chk("t1_ready", {req0_ready, req1_ready}, 0);
    chk("t1_rsp", {rsp0_valid, rsp1_valid}, 0);
    chk("t1_rdata", {rsp0_rdata, rsp1_rdata}, 16'h0000);

    // T2: req0 write then read same address
    txn(0, 1, 4'd3, 8'hA5, 8'h00);
    txn(0, 0, 4'd3, 8'h00, 8'hA5);

    // T3: both requesters valid every cycle; grants alternate starting at 0
    do_reset();
    set_req(0, 1, 1, 4'd1, 8'h11);
    set_req(1, 1, 1, 4'd2, 8'h22);
    #1;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        tick();
        n++;
      end
      chk("t3_rdy_wait", n, 0);
      chk("t3_both_rdy", req0_ready && req1_ready, 0);
      g = req1_ready ? 1 : 0;
      chk("t3_gnt", g, i % 2);
      tick();
      chk("t3_acc_addr", ram_addr, (i % 2 == 0) ? 4'd1 : 4'd2);
      tick();
      tick();
      chk("t3_rsp0", rsp0_valid, (g == 0) ? 1 : 0);
      chk("t3_rsp1", rsp1_valid, (g == 1) ? 1 : 0);
    end
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    tick();
    txn(1, 0, 4'd1, 8'h00, 8'h11);
    txn(0, 0, 4'd2, 8'h00, 8'h22);

    // T4: preload 0..3, then requester 1 alone reads them back to back
    for (int i = 0; i < 4; i++) txn(0, 1, 4'(i), 8'(8'h30 + i), 8'h00);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      set_req(1, 1, 0, 4'(i), 8'h00);
      #1;
      chk("t4_rdy", req1_ready, 1);
      tick();
      set_req(1, 0, 0, 0, 0);
      tick();
      tick();
      chk("t4_rsp", rsp1_valid, 1);
      chk("t4_rdata", rsp1_rdata, 8'(8'h30 + i));
    end
    chk("t4_cycles", cyc - t0, 12);
    tick();

    // T5: reset during the ACCESS cycle of a write
    set_req(0, 1, 1, 4'd5, 8'h5A);
    #1;
    chk("t5_rdy", req0_ready, 1);
    tick();
    set_req(0, 0, 0, 0, 0);
    chk("t5_in_access", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_ram_we", ram_we, 0);
    chk("t5_rsp0", rsp0_valid, 0);
    tick();
    chk("t5_rsp0_late", rsp0_valid, 0);
    chk("t5_busy_late", busy, 0);

    // T6: top address write must not alias onto address 0
    txn(0, 1, 4'd15, 8'hFF, 8'h00);
    txn(1, 0, 4'd0, 8'h00, 8'h30);
    txn(0, 0, 4'd15, 8'h00, 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
